jk_updown_counter: RTL

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_updown_counter.sv | 98 +++++++++
 1 files changed

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from per-bit JK stages, with a registered
// terminal-count pulse and a sticky overflow flag. Define JKCNT_SATURATE_EN to saturate instead of wrapping.
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_atTop;
  logic             w_atBottom;
  logic             w_wrap;
  logic             w_force;

  // The target count is computed first. Ordinary counting translates into
  // j = k = toggle, while load and wrap drive each stage as a direct set or
  // reset. Both paths keep every stage's excitation fully defined.
  always_comb begin
    w_atTop    = (r_q == MAX_VAL);
    w_atBottom = (r_q == '0);
    w_wrap     = !load && en && (up ? w_atTop : w_atBottom);
    w_next     = r_q;
    w_force    = 1'b0;
    if (load) begin
      w_force = 1'b1;
      w_next  = ({1'b0, din} >= MOD_EXT) ? MAX_VAL : din;
    end else if (w_wrap) begin
`ifdef JKCNT_SATURATE_EN
      w_next  = r_q;
`else
      w_force = 1'b1;
      w_next  = up ? '0 : MAX_VAL;
`endif
    end else if (en) begin
      w_next  = up ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
    end
    if (w_force) begin
      w_j = w_next;
      w_k = ~w_next;
    end else begin
      w_j = r_q ^ w_next;
      w_k = r_q ^ w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({w_j[i], w_k[i]})
          2'b01:   r_q[i] <= 1'b0;
          2'b10:   r_q[i] <= 1'b1;
          2'b11:   r_q[i] <= ~r_q[i];
          default: r_q[i] <= r_q[i];
        endcase
      end
    end
  end

  // A wrap or blocked step wins over a coincident clear, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_tc <= w_wrap;
      if (w_wrap)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  assign q   = r_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

endmodule
